bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one external Wishbone-style 64-bit memory bus (X-bus) between the instruction-fetch master (F-bus, from stage_f) and the data/load-store master (M-bus).
- Arbitrates per transfer and routes acks and read data back to the owner.
- Adapts 32-bit instruction fetches onto the 64-bit bus.
- Aborts hung transfers with a watchdog.

Parameters:
FAIR, 1, 1 = alternate grants when both masters request; 0 = M has strict priority over F.
TIMEOUT_CYCLES, 255, maximum X-bus transfer length in cycles before abort; 0 disables the watchdog.

Ports:
clk_i  in  1  clock; all state changes on rising edge
reset_i  in  1  asynchronous, active-high reset
f_cyc_i  in  1  F-bus transfer request
f_adr_i  in  62  F word address [63:2]
f_ack_o  out  1  F transfer complete
f_dat_o  out  32  F instruction word
f_err_o  out  1  F transfer aborted by timeout
m_cyc_i  in  1  M-bus transfer request
m_we_i  in  1  M write enable
m_adr_i  in  61  M doubleword address [63:3]
m_sel_i  in  8  M byte lane selects
m_dat_i  in  64  M write data
m_ack_o  out  1  M transfer complete
m_dat_o  out  64  M read data
m_err_o  out  1  M transfer aborted by timeout
x_cyc_o  out  1  X-bus cycle
x_we_o  out  1  X write enable
x_adr_o  out  61  X address [63:3]
x_sel_o  out  8  X byte lane selects
x_dat_o  out  64  X write data
x_ack_i  in  1  X transfer complete
x_dat_i  in  64  X read data

Behaviour:
- State register: IDLE, GNT_F, GNT_M.
- Additional registers:
  - last grant (reset value F, so M wins the first contention);
  - watchdog counter (reset value 0);
  - err pulse registers.
- Reset (asynchronous): state IDLE. All x_* outputs, acks and errs read 0 immediately, including when reset asserts mid-transfer. No ack is forwarded while reset is asserted.
- X-bus outputs are a combinational mux on the registered state:
  - IDLE: all x_* are 0.
  - GNT_M: x_cyc_o=m_cyc_i; we, adr, sel and dat pass through from M.
  - GNT_F: x_cyc_o=f_cyc_i; x_we_o=0; x_adr_o=f_adr_i[63:3]; x_sel_o=F0 if f_adr_i[2] else 0F; x_dat_o=0.
- Ack routing, combinational:
  - f_ack_o = GNT_F & f_cyc_i & x_ack_i.
  - m_ack_o = GNT_M & m_cyc_i & x_ack_i.
  - x_ack_i is ignored in IDLE.
- Read data:
  - m_dat_o = x_dat_i.
  - f_dat_o = x_dat_i[63:32] if f_adr_i[2] else x_dat_i[31:0].
- IDLE transitions:
  - Only one master requesting: grant it.
  - Both requesting: FAIR=1 grants the master that was not last granted; FAIR=0 grants M.
  - The grant takes effect at the next edge, so there is one cycle of arbitration latency from IDLE.
- GNT_X with ack (x_ack_i & owner cyc):
  - last := X.
  - Next state, FAIR=1: the other master if it is requesting, else stay GNT_X.
  - Next state, FAIR=0: GNT_M if m_cyc_i, else GNT_F if f_cyc_i, else IDLE.
  - A switch on ack has zero idle cycles on the X-bus.
- GNT_X, owner cyc low, no ack: go to IDLE (owner released the bus). x_cyc_o is already low via the mux.
- Watchdog:
  - The counter increments each GNT cycle without ack.
  - It clears on ack, on any state change and in IDLE.
  - Timeout fires when TIMEOUT_CYCLES≠0, counter==TIMEOUT_CYCLES-1, and there is no ack. The X-bus cycle has then lasted TIMEOUT_CYCLES cycles.
  - On timeout at the next edge: state IDLE, last := owner, owner's err register set.
  - The err output is a 1-cycle pulse in the first IDLE cycle.
  - Ack in the timeout cycle wins; no err is raised.
- A master dropping cyc mid-transfer is legal. The transfer is abandoned and no ack or err is given.
- Outputs hold stable across X-bus wait states as long as the owner's inputs are stable.

Test Plan:
1. Async reset:
   - Stimulus: assert reset_i between clock edges during GNT_M with a write in flight.
   - Required: x_cyc_o, x_we_o, x_sel_o, m_ack_o and f_ack_o go to 0 without a clock edge. After release, state is IDLE.
2. F fetch:
   - Stimulus: f_cyc_i=1 with f_adr_i = FFFF_FFFF_FFFF_FF04>>2, and x_dat_i=1122334455667788.
   - Required: x_cyc_o=1 one cycle later, x_adr_o=FFFF_FFFF_FFFF_FF00>>3, x_sel_o=F0, x_we_o=0. f_dat_o=11223344, and f_ack_o follows x_ack_i in the same cycle.
   - Repeat at …FF08: x_sel_o=0F, f_dat_o=55667788.
3. Wait states:
   - Stimulus: hold x_ack_i=0 for 3 cycles during an F fetch.
   - Required: x_cyc_o and x_adr_o are stable and f_ack_o=0. On x_ack_i=1, f_ack_o=1 for that single cycle.
4. FAIR=1 contention:
   - Stimulus: immediately after reset, raise f_cyc_i and m_cyc_i together, and ack every X cycle.
   - Required: the grant order is M, F, M, F, with no idle X cycle between transfers.
5. FAIR=0 priority:
   - Stimulus: F is streaming fetches; m_cyc_i rises.
   - Required: after F's current ack, the next X cycle is M's. F is not granted again until m_cyc_i drops.
6. Timeout:
   - Stimulus: TIMEOUT_CYCLES=4, an M write with x_ack_i held at 0, and f_cyc_i pending.
   - Required: x_cyc_o is high for exactly 4 cycles then low, m_err_o pulses once, m_ack_o never asserts. F is granted on the next edge.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one 64-bit Wishbone-style X-bus between
// instruction fetch (F, 32-bit words) and load/store (M, 64-bit doublewords).
// Grants are per transfer; a watchdog aborts transfers that never ack.
module bus_arbiter #(
    parameter bit          FAIR           = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    // F-bus (instruction fetch)
    input  logic        f_cyc_i,
    input  logic [61:0] f_adr_i,
    output logic        f_ack_o,
    output logic [31:0] f_dat_o,
    output logic        f_err_o,
    // M-bus (load/store)
    input  logic        m_cyc_i,
    input  logic        m_we_i,
    input  logic [60:0] m_adr_i,
    input  logic [7:0]  m_sel_i,
    input  logic [63:0] m_dat_i,
    output logic        m_ack_o,
    output logic [63:0] m_dat_o,
    output logic        m_err_o,
    // X-bus (shared memory bus)
    output logic        x_cyc_o,
    output logic        x_we_o,
    output logic [60:0] x_adr_o,
    output logic [7:0]  x_sel_o,
    output logic [63:0] x_dat_o,
    input  logic        x_ack_i,
    input  logic [63:0] x_dat_i
);

    localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_M = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_m_q, last_m_d;   // 1: M was granted last, 0: F
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              f_err_q, f_err_d;
    logic              m_err_q, m_err_d;

    logic              owner_is_m;
    logic              owner_cyc;
    logic              other_cyc;
    logic              ack;
    logic              timeout;
    state_e            other_state;

    // Owner-relative view of the current grant
    always_comb begin
        owner_is_m  = (state_q == GNT_M);
        owner_cyc   = 1'b0;
        other_cyc   = 1'b0;
        other_state = IDLE;
        if (state_q == GNT_F) begin
            owner_cyc   = f_cyc_i;
            other_cyc   = m_cyc_i;
            other_state = GNT_M;
        end else if (state_q == GNT_M) begin
            owner_cyc   = m_cyc_i;
            other_cyc   = f_cyc_i;
            other_state = GNT_F;
        end
        ack     = owner_cyc & x_ack_i;
        timeout = WD_EN && (wd_q == WD_W'(WD_LAST)) && !ack;
    end

    // X-bus request mux, driven from the registered grant
    always_comb begin
        x_cyc_o = 1'b0;
        x_we_o  = 1'b0;
        x_adr_o = '0;
        x_sel_o = '0;
        x_dat_o = '0;
        case (state_q)
            GNT_F: begin
                x_cyc_o = f_cyc_i;
                x_adr_o = f_adr_i[61:1];
                x_sel_o = f_adr_i[0] ? 8'hF0 : 8'h0F;
            end
            GNT_M: begin
                x_cyc_o = m_cyc_i;
                x_we_o  = m_we_i;
                x_adr_o = m_adr_i;
                x_sel_o = m_sel_i;
                x_dat_o = m_dat_i;
            end
            default: ;
        endcase
    end

    // Ack and read-data return to the owning master
    always_comb begin
        f_ack_o = (state_q == GNT_F) & f_cyc_i & x_ack_i;
        m_ack_o = (state_q == GNT_M) & m_cyc_i & x_ack_i;
        f_dat_o = f_adr_i[0] ? x_dat_i[63:32] : x_dat_i[31:0];
        m_dat_o = x_dat_i;
        f_err_o = f_err_q;
        m_err_o = m_err_q;
    end

    // Arbitration, grant hand-over and watchdog next-state logic
    always_comb begin
        state_d  = state_q;
        last_m_d = last_m_q;
        wd_d     = '0;
        f_err_d  = 1'b0;
        m_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && f_cyc_i) begin
                    state_d = (!FAIR || !last_m_q) ? GNT_M : GNT_F;
                end else if (m_cyc_i) begin
                    state_d = GNT_M;
                end else if (f_cyc_i) begin
                    state_d = GNT_F;
                end
            end
            default: begin
                if (ack) begin
                    last_m_d = owner_is_m;
                    if (FAIR) begin
                        state_d = other_cyc ? other_state : state_q;
                    end else if (m_cyc_i) begin
                        state_d = GNT_M;
                    end else if (f_cyc_i) begin
                        state_d = GNT_F;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!owner_cyc) begin
                    // owner abandoned the transfer: no ack, no err
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d  = IDLE;
                    last_m_d = owner_is_m;
                    m_err_d  = owner_is_m;
                    f_err_d  = !owner_is_m;
                end else if (WD_EN) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
        endcase
    end

    // State, last-grant, watchdog and err-pulse registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            last_m_q <= 1'b0;
            wd_q     <= '0;
            f_err_q  <= 1'b0;
            m_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_m_q <= last_m_d;
            wd_q     <= wd_d;
            f_err_q  <= f_err_d;
            m_err_q  <= m_err_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: instance a is FAIR=1, instance b is FAIR=0,
// both with a 4-cycle watchdog; inputs are shared.
module tb_bus_arbiter;

    localparam logic [61:0] F_ADR_04 = 62'h3FFF_FFFF_FFFF_FFC1;
    localparam logic [61:0] F_ADR_08 = 62'h3FFF_FFFF_FFFF_FFC2;
    localparam logic [60:0] X_ADR_00 = 61'h1FFF_FFFF_FFFF_FFE0;
    localparam logic [60:0] X_ADR_08 = 61'h1FFF_FFFF_FFFF_FFE1;
    localparam logic [60:0] M_ADR    = 61'h0123_4567_89AB_CDE;
    localparam logic [63:0] M_DAT    = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] X_DAT    = 64'h1122_3344_5566_7788;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        f_cyc_i, m_cyc_i, m_we_i, x_ack_i;
    logic [61:0] f_adr_i;
    logic [60:0] m_adr_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_dat_i, x_dat_i;

    logic        f_ack_a, f_err_a, m_ack_a, m_err_a, x_cyc_a, x_we_a;
    logic [31:0] f_dat_a;
    logic [63:0] m_dat_a, x_dat_a;
    logic [60:0] x_adr_a;
    logic [7:0]  x_sel_a;

    logic        f_ack_b, f_err_b, m_ack_b, m_err_b, x_cyc_b, x_we_b;
    logic [31:0] f_dat_b;
    logic [63:0] m_dat_b, x_dat_b;
    logic [60:0] x_adr_b;
    logic [7:0]  x_sel_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.FAIR(1'b1), .TIMEOUT_CYCLES(4)) dut_a (
        .clk_i(clk), .reset_i(reset_i),
        .f_cyc_i(f_cyc_i), .f_adr_i(f_adr_i), .f_ack_o(f_ack_a), .f_dat_o(f_dat_a), .f_err_o(f_err_a),
        .m_cyc_i(m_cyc_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_a), .m_dat_o(m_dat_a), .m_err_o(m_err_a),
        .x_cyc_o(x_cyc_a), .x_we_o(x_we_a), .x_adr_o(x_adr_a), .x_sel_o(x_sel_a), .x_dat_o(x_dat_a),
        .x_ack_i(x_ack_i), .x_dat_i(x_dat_i)
    );

    bus_arbiter #(.FAIR(1'b0), .TIMEOUT_CYCLES(4)) dut_b (
        .clk_i(clk), .reset_i(reset_i),
        .f_cyc_i(f_cyc_i), .f_adr_i(f_adr_i), .f_ack_o(f_ack_b), .f_dat_o(f_dat_b), .f_err_o(f_err_b),
        .m_cyc_i(m_cyc_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_b), .m_dat_o(m_dat_b), .m_err_o(m_err_b),
        .x_cyc_o(x_cyc_b), .x_we_o(x_we_b), .x_adr_o(x_adr_b), .x_sel_o(x_sel_b), .x_dat_o(x_dat_b),
        .x_ack_i(x_ack_i), .x_dat_i(x_dat_i)
    );

    // advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (x_cyc_a !== 1'b0) begin n_err++; $display("FAIL rst_x_cyc got=%h want=0", x_cyc_a); end
        n_vec++; if (f_err_a !== 1'b0 || m_err_a !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b%b want=00", f_err_a, m_err_a); end
        reset_i = 1'b0;
        m_cyc_i = 1'b1; m_we_i = 1'b1; m_sel_i = 8'hFF; m_adr_i = M_ADR; m_dat_i = M_DAT;
        tick();
        n_vec++; if (x_cyc_a !== 1'b1 || x_we_a !== 1'b1) begin n_err++; $display("FAIL wr_cyc_we got=%b%b want=11", x_cyc_a, x_we_a); end
        n_vec++; if (x_adr_a !== M_ADR || x_dat_a !== M_DAT || x_sel_a !== 8'hFF) begin n_err++; $display("FAIL wr_pass got adr=%h dat=%h sel=%h", x_adr_a, x_dat_a, x_sel_a); end
        x_ack_i = 1'b1;
        #1;
        n_vec++; if (m_ack_a !== 1'b1) begin n_err++; $display("FAIL wr_ack got=%b want=1", m_ack_a); end
        reset_i = 1'b1;
        #1;
        n_vec++; if (x_cyc_a !== 1'b0 || x_we_a !== 1'b0 || x_sel_a !== 8'h00) begin n_err++; $display("FAIL async_rst_x got cyc=%b we=%b sel=%h want 0", x_cyc_a, x_we_a, x_sel_a); end
        n_vec++; if (m_ack_a !== 1'b0 || f_ack_a !== 1'b0 || m_ack_b !== 1'b0) begin n_err++; $display("FAIL async_rst_ack got m=%b f=%b mb=%b want 0", m_ack_a, f_ack_a, m_ack_b); end
        m_cyc_i = 1'b0; m_we_i = 1'b0; m_sel_i = 8'h00; x_ack_i = 1'b0;
        tick();
        reset_i = 1'b0;
        m_cyc_i = 1'b1;
        #1;
        n_vec++; if (x_cyc_a !== 1'b0) begin n_err++; $display("FAIL post_rst_idle got=%b want=0", x_cyc_a); end
        tick();
        n_vec++; if (x_cyc_a !== 1'b1) begin n_err++; $display("FAIL post_rst_grant got=%b want=1", x_cyc_a); end
        m_cyc_i = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        f_cyc_i = 1'b1; f_adr_i = F_ADR_04; x_dat_i = X_DAT; x_ack_i = 1'b0;
        #1;
        n_vec++; if (x_cyc_a !== 1'b0) begin n_err++; $display("FAIL fetch_latency got=%b want=0", x_cyc_a); end
        tick();
        n_vec++; if (x_cyc_a !== 1'b1 || x_we_a !== 1'b0) begin n_err++; $display("FAIL fetch04_cyc_we got=%b%b want=10", x_cyc_a, x_we_a); end
        n_vec++; if (x_adr_a !== X_ADR_00) begin n_err++; $display("FAIL fetch04_adr got=%h want=%h", x_adr_a, X_ADR_00); end
        n_vec++; if (x_sel_a !== 8'hF0) begin n_err++; $display("FAIL fetch04_sel got=%h want=f0", x_sel_a); end
        n_vec++; if (f_dat_a !== 32'h1122_3344) begin n_err++; $display("FAIL fetch04_dat got=%h want=11223344", f_dat_a); end
        n_vec++; if (f_ack_a !== 1'b0) begin n_err++; $display("FAIL fetch04_noack got=%b want=0", f_ack_a); end
        x_ack_i = 1'b1;
        #1;
        n_vec++; if (f_ack_a !== 1'b1 || m_ack_a !== 1'b0) begin n_err++; $display("FAIL fetch04_ack got f=%b m=%b want 1 0", f_ack_a, m_ack_a); end
        tick();
        x_ack_i = 1'b0; f_adr_i = F_ADR_08;
        #1;
        n_vec++; if (x_adr_a !== X_ADR_08 || x_sel_a !== 8'h0F) begin n_err++; $display("FAIL fetch08_adr_sel got adr=%h sel=%h", x_adr_a, x_sel_a); end
        n_vec++; if (f_dat_a !== 32'h5566_7788 || f_ack_a !== 1'b0) begin n_err++; $display("FAIL fetch08_dat got=%h ack=%b want 55667788 0", f_dat_a, f_ack_a); end
        x_ack_i = 1'b1;
        #1;
        n_vec++; if (f_ack_a !== 1'b1) begin n_err++; $display("FAIL fetch08_ack got=%b want=1", f_ack_a); end
        tick();
        f_cyc_i = 1'b0; x_ack_i = 1'b0;
        #1;
        n_vec++; if (x_cyc_a !== 1'b0) begin n_err++; $display("FAIL fetch_release got=%b want=0", x_cyc_a); end
        tick();
    endtask

    task automatic test_wait_states();
        f_cyc_i = 1'b1; f_adr_i = F_ADR_04; x_ack_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (x_cyc_a !== 1'b1 || x_adr_a !== X_ADR_00 || f_ack_a !== 1'b0) begin
                n_err++; $display("FAIL wait_%0d got cyc=%b adr=%h ack=%b", i, x_cyc_a, x_adr_a, f_ack_a);
            end
            tick();
        end
        x_ack_i = 1'b1;
        #1;
        n_vec++; if (f_ack_a !== 1'b1 || x_cyc_a !== 1'b1) begin n_err++; $display("FAIL wait_ack_4th got ack=%b cyc=%b want 1 1", f_ack_a, x_cyc_a); end
        tick();
        x_ack_i = 1'b0; f_cyc_i = 1'b0;
        #1;
        n_vec++; if (f_ack_a !== 1'b0 || f_err_a !== 1'b0) begin n_err++; $display("FAIL wait_ack_wins got ack=%b err=%b want 0 0", f_ack_a, f_err_a); end
        tick();
    endtask

    task automatic test_fair_contention();
        logic exp_m;
        reset_pulse();
        m_adr_i = M_ADR; m_we_i = 1'b0; f_adr_i = F_ADR_04;
        m_cyc_i = 1'b1; f_cyc_i = 1'b1; x_ack_i = 1'b1;
        #1;
        n_vec++; if (x_cyc_a !== 1'b0 || m_ack_a !== 1'b0) begin n_err++; $display("FAIL fair_idle got cyc=%b ack=%b want 0 0", x_cyc_a, m_ack_a); end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_m = (i % 2 == 0);
            n_vec++;
            if (x_cyc_a !== 1'b1 || m_ack_a !== exp_m || f_ack_a !== !exp_m ||
                x_adr_a !== (exp_m ? M_ADR : X_ADR_00)) begin
                n_err++; $display("FAIL fair_order_%0d got cyc=%b m=%b f=%b adr=%h want m=%b", i, x_cyc_a, m_ack_a, f_ack_a, x_adr_a, exp_m);
            end
            n_vec++; if (m_ack_b !== 1'b1 || f_ack_b !== 1'b0) begin n_err++; $display("FAIL prio_first_%0d got m=%b f=%b want 1 0", i, m_ack_b, f_ack_b); end
        end
        m_cyc_i = 1'b0; f_cyc_i = 1'b0; x_ack_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_priority();
        reset_pulse();
        f_cyc_i = 1'b1; f_adr_i = F_ADR_04; x_ack_i = 1'b1;
        tick();
        n_vec++; if (f_ack_b !== 1'b1) begin n_err++; $display("FAIL prio_stream0 got=%b want=1", f_ack_b); end
        tick();
        m_cyc_i = 1'b1; m_we_i = 1'b1;
        #1;
        n_vec++; if (f_ack_b !== 1'b1 || m_ack_b !== 1'b0) begin n_err++; $display("FAIL prio_cur_f got f=%b m=%b want 1 0", f_ack_b, m_ack_b); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (m_ack_b !== 1'b1 || f_ack_b !== 1'b0 || x_we_b !== 1'b1) begin
                n_err++; $display("FAIL prio_m_%0d got m=%b f=%b we=%b want 1 0 1", i, m_ack_b, f_ack_b, x_we_b);
            end
        end
        m_cyc_i = 1'b0; m_we_i = 1'b0;
        #1;
        n_vec++; if (x_cyc_b !== 1'b0 || f_ack_b !== 1'b0) begin n_err++; $display("FAIL prio_mdrop got cyc=%b f=%b want 0 0", x_cyc_b, f_ack_b); end
        tick();
        n_vec++; if (x_cyc_b !== 1'b0) begin n_err++; $display("FAIL prio_idle got=%b want=0", x_cyc_b); end
        tick();
        n_vec++; if (f_ack_b !== 1'b1) begin n_err++; $display("FAIL prio_f_again got=%b want=1", f_ack_b); end
        f_cyc_i = 1'b0; x_ack_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        reset_pulse();
        m_cyc_i = 1'b1; m_we_i = 1'b1; f_cyc_i = 1'b1; x_ack_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (x_cyc_a !== 1'b1 || x_we_a !== 1'b1 || m_ack_a !== 1'b0 || m_err_a !== 1'b0) begin
                n_err++; $display("FAIL to_hold_%0d got cyc=%b we=%b ack=%b err=%b", i, x_cyc_a, x_we_a, m_ack_a, m_err_a);
            end
            tick();
        end
        n_vec++; if (x_cyc_a !== 1'b0 || m_ack_a !== 1'b0) begin n_err++; $display("FAIL to_abort got cyc=%b ack=%b want 0 0", x_cyc_a, m_ack_a); end
        n_vec++; if (m_err_a !== 1'b1 || f_err_a !== 1'b0 || m_err_b !== 1'b1) begin n_err++; $display("FAIL to_err got m=%b f=%b mb=%b want 1 0 1", m_err_a, f_err_a, m_err_b); end
        tick();
        n_vec++; if (x_cyc_a !== 1'b1 || x_we_a !== 1'b0 || x_sel_a !== 8'hF0) begin n_err++; $display("FAIL to_next_f got cyc=%b we=%b sel=%h", x_cyc_a, x_we_a, x_sel_a); end
        n_vec++; if (m_err_a !== 1'b0) begin n_err++; $display("FAIL to_err_pulse got=%b want=0", m_err_a); end
        m_cyc_i = 1'b0; f_cyc_i = 1'b0; m_we_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset_i = 1'b1;
        f_cyc_i = 1'b0; f_adr_i = '0;
        m_cyc_i = 1'b0; m_we_i = 1'b0; m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
        x_ack_i = 1'b0; x_dat_i = '0;
        test_reset();
        test_fetch();
        test_wait_states();
        test_fair_contention();
        test_priority();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
